// File: rtl/scanout_engine.sv
// Raster scan-out engine: timing generator, upscaled framebuffer addressing,
// latency-aligned pixel/sync output and tear-free front/back buffer swap.
module scanout_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int ADDR_W      = 24,
    parameter int SCALE_SHIFT = 0,
    parameter int RD_LAT      = 1,
    parameter int COLOR_MODE  = 0,
    parameter int SYNC_POL    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] base0_i,
    input  logic [ADDR_W-1:0] base1_i,
    input  logic              swap_req_i,
    output logic              front_sel_o,
    output logic              swap_done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [7:0]        mem_q_i,
    output logic [23:0]       rgb_o,
    output logic              de_o,
    output logic              hs_o,
    output logic              vs_o,
    output logic              frame_start_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int ROW_STEP = H_ACTIVE >> SCALE_SHIFT;
    localparam int V_MASK   = (1 << SCALE_SHIFT) - 1;
    localparam int PD       = RD_LAT + 2;
    localparam logic SYNC_LVL = 1'(SYNC_POL);

    logic [HW-1:0]        h_cnt_q;
    logic [VW-1:0]        v_cnt_q;
    logic [ADDR_W-1:0]    row_off_q;
    logic [ADDR_W-1:0]    base_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic                 mem_rd_q;
    logic                 front_sel_q;
    logic                 pending_q;
    logic                 swap_done_q;
    logic [23:0]          rgb_q;
    // Per-stage flags {de, hs, vs, frame_start}; stage 0 travels with mem_addr.
    logic [PD-1:0][3:0]   pipe_q;

    logic                 h_last;
    logic                 v_last;
    logic                 active;
    logic                 hs_act;
    logic                 vs_act;
    logic                 fs_act;
    logic [ADDR_W-1:0]    base_live;
    logic [ADDR_W-1:0]    base_line;
    logic [ADDR_W-1:0]    addr_d;
    logic [VW-1:0]        v_next;
    logic [3:0]           stage_d;
    logic [23:0]          pix_d;

    always_comb begin
        h_last    = int'(h_cnt_q) == H_TOTAL - 1;
        v_last    = int'(v_cnt_q) == V_TOTAL - 1;
        active    = en_i && (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        hs_act    = (int'(h_cnt_q) >= H_ACTIVE + H_FP) && (int'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC);
        vs_act    = (int'(v_cnt_q) >= V_ACTIVE + V_FP) && (int'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC);
        fs_act    = active && (h_cnt_q == '0) && (v_cnt_q == '0);
        base_live = front_sel_q ? base1_i : base0_i;
        // The base is captured at column 0 so mid-line writes only affect the next line.
        base_line = (h_cnt_q == '0) ? base_live : base_q;
        addr_d    = base_line + row_off_q + ADDR_W'(h_cnt_q >> SCALE_SHIFT);
        v_next    = v_cnt_q + 1'b1;
        stage_d   = {active, hs_act, vs_act, fs_act};
        if (COLOR_MODE == 1) begin
            pix_d = {mem_q_i[7:5], mem_q_i[7:5], mem_q_i[7:6],
                     mem_q_i[4:2], mem_q_i[4:2], mem_q_i[4:3],
                     {4{mem_q_i[1:0]}}};
        end else begin
            pix_d = {mem_q_i, mem_q_i, mem_q_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            row_off_q   <= '0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            rgb_q       <= '0;
            pipe_q      <= '0;
        end else if (!en_i) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            row_off_q   <= '0;
            mem_rd_q    <= 1'b0;
            swap_done_q <= 1'b0;
            pending_q   <= pending_q | swap_req_i;
            rgb_q       <= '0;
            pipe_q      <= '0;
        end else begin
            swap_done_q <= 1'b0;
            if (h_last) begin
                h_cnt_q <= '0;
                if (v_last) begin
                    v_cnt_q   <= '0;
                    row_off_q <= '0;
                end else begin
                    v_cnt_q <= v_next;
                    if ((int'(v_next) & V_MASK) == 0) begin
                        row_off_q <= row_off_q + ADDR_W'(ROW_STEP);
                    end
                end
            end else begin
                h_cnt_q <= h_cnt_q + 1'b1;
            end

            if (h_cnt_q == '0) begin
                base_q <= base_live;
            end

            if (h_last && v_last && (pending_q || swap_req_i)) begin
                front_sel_q <= ~front_sel_q;
                pending_q   <= 1'b0;
                swap_done_q <= 1'b1;
            end else begin
                pending_q <= pending_q | swap_req_i;
            end

            mem_rd_q <= active;
            if (active) begin
                mem_addr_q <= addr_d;
            end

            pipe_q <= {pipe_q[PD-2:0], stage_d};
            rgb_q  <= pipe_q[RD_LAT][3] ? pix_d : '0;
        end
    end

    assign front_sel_o   = front_sel_q;
    assign swap_done_o   = swap_done_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_rd_o      = mem_rd_q;
    assign rgb_o         = rgb_q;
    assign de_o          = pipe_q[PD-1][3];
    assign hs_o          = pipe_q[PD-1][2] ? SYNC_LVL : ~SYNC_LVL;
    assign vs_o          = pipe_q[PD-1][1] ? SYNC_LVL : ~SYNC_LVL;
    assign frame_start_o = pipe_q[PD-1][0];

endmodule

// File: tb/tb_scanout_engine.sv
// Directed bench for scanout_engine on a 16x8 raster: two instances cover
// 2x upscale with 3-clock memory latency (gray) and RGB332 with active-high syncs.
module tb_scanout_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, swap_req, swap_req_c;
    logic [23:0] base0, base1, base_c;
    logic        front_sel, swap_done, mem_rd, de, hs, vs, frame_start;
    logic [23:0] mem_addr, rgb;
    logic        front_sel_c, swap_done_c, mem_rd_c, de_c, hs_c, vs_c, frame_start_c;
    logic [23:0] mem_addr_c, rgb_c;
    logic [7:0]  mem_q, mem_q_c;
    logic [7:0]  mq1 = 8'h0, mq2 = 8'h0, mq3 = 8'h0;

    int n_checks = 0;
    int n_fail   = 0;

    scanout_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .ADDR_W(24), .SCALE_SHIFT(1), .RD_LAT(3), .COLOR_MODE(0), .SYNC_POL(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .base0_i(base0), .base1_i(base1), .swap_req_i(swap_req),
        .front_sel_o(front_sel), .swap_done_o(swap_done),
        .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_q_i(mem_q),
        .rgb_o(rgb), .de_o(de), .hs_o(hs), .vs_o(vs), .frame_start_o(frame_start)
    );

    scanout_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .ADDR_W(24), .SCALE_SHIFT(0), .RD_LAT(1), .COLOR_MODE(1), .SYNC_POL(1)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .base0_i(base_c), .base1_i(base_c), .swap_req_i(swap_req_c),
        .front_sel_o(front_sel_c), .swap_done_o(swap_done_c),
        .mem_addr_o(mem_addr_c), .mem_rd_o(mem_rd_c), .mem_q_i(mem_q_c),
        .rgb_o(rgb_c), .de_o(de_c), .hs_o(hs_c), .vs_o(vs_c), .frame_start_o(frame_start_c)
    );

    // Memory returning the low address byte three clocks after the read.
    always @(posedge clk) begin
        mq1 <= mem_addr[7:0];
        mq2 <= mq1;
        mq3 <= mq2;
    end
    assign mem_q = mq3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel index p counts counter states since restart; 16 clocks per line, 8 lines per frame.
    function automatic logic px_act(input int p);
        return (p >= 0) && ((p % 16) < 8) && (((p / 16) % 8) < 4);
    endfunction

    function automatic logic hs_on(input int p);
        return (p >= 0) && ((p % 16) >= 10) && ((p % 16) < 12);
    endfunction

    function automatic logic vs_on(input int p);
        return (p >= 0) && (((p / 16) % 8) == 5);
    endfunction

    // Frame 2 of the long run is the only one scanned from buffer 1.
    function automatic logic [23:0] px_addr(input int p);
        int base;
        base = ((p / 128) == 2) ? 32'h800 : 32'h100;
        return 24'(base + (((p / 16) % 8) >> 1) * 4 + ((p % 16) >> 1));
    endfunction

    logic [23:0] line_seq [0:7] = '{24'h100, 24'h100, 24'h101, 24'h101,
                                    24'h102, 24'h102, 24'h103, 24'h103};

    task automatic scan(input int ncyc, input bit do_swap);
        for (int n = 1; n <= ncyc; n++) begin
            int q, r, qc;
            logic [23:0] a;
            logic [23:0] exp_rgb;
            logic [23:0] exp_rgb_c;
            @(negedge clk);
            q  = n - 5;
            r  = n - 1;
            qc = n - 3;
            a  = px_addr(q);
            exp_rgb   = px_act(q) ? {a[7:0], a[7:0], a[7:0]} : 24'h0;
            exp_rgb_c = px_act(qc) ? ((mem_q_c == 8'hE3) ? 24'hFF00FF : 24'h00FF00) : 24'h0;

            chk("mem_rd", mem_rd, px_act(r));
            if (px_act(r)) chk("mem_addr", mem_addr, px_addr(r));
            chk("de", de, px_act(q));
            chk("rgb", rgb, exp_rgb);
            chk("hs", hs, !hs_on(q));
            chk("vs", vs, !vs_on(q));
            chk("frame_start", frame_start, (q >= 0) && (q % 128 == 0));
            chk("front_sel", front_sel, do_swap && (n >= 256) && (n < 384));
            chk("swap_done", swap_done, do_swap && ((n == 256) || (n == 384)));
            chk("de_c", de_c, px_act(qc));
            chk("hs_c", hs_c, hs_on(qc));
            chk("vs_c", vs_c, vs_on(qc));
            chk("rgb_c", rgb_c, exp_rgb_c);
            chk("frame_start_c", frame_start_c, (qc >= 0) && (qc % 128 == 0));

            if (n == 54) chk("addr_h5_v3", mem_addr, 32'h106);
            if (n >= 1 && n <= 8) chk("line0_seq", mem_addr, line_seq[n-1]);
            if (n >= 17 && n <= 24) chk("line1_seq", mem_addr, line_seq[n-17]);
            if (n == 39) chk("rgb_lat_0x05", rgb, 32'h050505);
            if (do_swap && n == 257) chk("swap_first_addr", mem_addr, 32'h800);

            swap_req = do_swap && ((n == 150) || (n == 190) || (n == 383));
            if (do_swap && n == 200) mem_q_c = 8'h1C;
        end
    endtask

    task automatic reset_checks();
        chk("rst_de", de, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rgb", rgb, 32'h0);
        chk("rst_hs", hs, 1'b1);
        chk("rst_vs", vs, 1'b1);
        chk("rst_front_sel", front_sel, 1'b0);
        chk("rst_swap_done", swap_done, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_de_c", de_c, 1'b0);
        chk("rst_hs_c", hs_c, 1'b0);
        chk("rst_rgb_c", rgb_c, 32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        swap_req   = 1'b0;
        swap_req_c = 1'b0;
        base0      = 24'h100;
        base1      = 24'h800;
        base_c     = 24'h0;
        mem_q_c    = 8'hE3;
        repeat (3) @(negedge clk);
        reset_checks();

        rst = 1'b1;
        en  = 1'b1;
        scan(547, 1'b1);

        // Mid-line reset on line 2 of frame 4.
        rst = 1'b0;
        @(negedge clk);
        reset_checks();
        rst = 1'b1;
        scan(40, 1'b0);

        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("en_low_de", de, 1'b0);
            chk("en_low_mem_rd", mem_rd, 1'b0);
            chk("en_low_rgb", rgb, 32'h0);
            chk("en_low_addr_hold", mem_addr, 32'h107);
            chk("en_low_de_c", de_c, 1'b0);
        end
        en = 1'b1;
        scan(40, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
